des_left_shift: RTL and testbench

//  DES key-schedule rotation stage: rotates a 28-bit C or D key half by the
//  per-round amount (1 or 2). Sits between PC-1 and PC-2 in the key schedule.

---
 rtl/des_pkg.sv | 9 +
 rtl/des_left_shift_if.sv | 13 +
 rtl/des_rot28.sv | 11 +
 rtl/des_left_shift.sv | 30 +++
 tb/tb_des_left_shift.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule widths and per-round rotate amount
package des_pkg;
  localparam int DES_HALF_W = 28;
  localparam int DES_RW = 5;
  function automatic logic [1:0] des_shift_amt(input logic [DES_RW-1:0] round);
    return (round == '0 || round > DES_RW'(16)) ? 2'd0 :
           (round == DES_RW'(1) || round == DES_RW'(2) || round == DES_RW'(9) || round == DES_RW'(16)) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/des_left_shift_if.sv
// des_left_shift_if: key-half rotate request and combinational/registered results
interface des_left_shift_if;
  import des_pkg::*;
  logic [DES_RW-1:0]   round;
  logic [DES_HALF_W:1] in28;
  logic                in_valid;
  logic [DES_HALF_W:1] out28;
  logic [DES_HALF_W:1] out28_q;
  logic                out_valid;
  logic                round_err;
  modport master (output round, in28, in_valid, input out28, out28_q, out_valid, round_err);
  modport slave (input round, in28, in_valid, output out28, out28_q, out_valid, round_err);
endinterface

// File: rtl/des_rot28.sv
// des_rot28: DES "left" rotate of a 28-bit half (toward index 1) by 0, 1 or 2
module des_rot28
  import des_pkg::*;
(
  input  logic [1:0]          shift_i,
  input  logic [DES_HALF_W:1] in_i,
  output logic [DES_HALF_W:1] out_o
);
  assign out_o = (shift_i == 2'd1) ? {in_i[1], in_i[DES_HALF_W:2]} :
                 (shift_i == 2'd2) ? {in_i[2:1], in_i[DES_HALF_W:3]} : in_i;
endmodule

// File: rtl/des_left_shift.sv
// des_left_shift: per-round key-half rotation with error flag and registered copy
module des_left_shift
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  des_left_shift_if.slave  bus
);
  logic [1:0]          shift;
  logic [DES_HALF_W:1] rot;
  logic [DES_HALF_W:1] out_d, out_q;
  logic                vld_q;
  assign shift = des_shift_amt(bus.round);
  des_rot28 u_rot (.shift_i(shift), .in_i(bus.in28), .out_o(rot));
  // illegal rounds decode to shift 0, so they pass through instead of going X
  assign bus.round_err = (shift == 2'd0);
  assign bus.out28 = rot;
  assign out_d = bus.in_valid ? rot : out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= bus.in_valid;
    end
  end
  assign bus.out28_q = out_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_des_left_shift.sv
// tb_des_left_shift: directed-vector checks of rotation, error flag, register and reset
module tb_des_left_shift;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  des_left_shift_if bus();
  des_left_shift dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [4:0]  r_t [8] = '{5'd1, 5'd2, 5'd16, 5'd9, 5'd3, 5'd4, 5'd12, 5'd11};
  logic [27:0] i_t [8] = '{28'hAAAAAAA, 28'h1000000, 28'h0000001, 28'h2200000,
                           28'h4000000, 28'h0000001, 28'hC300000, 28'hAAAAAAA};
  logic [27:0] o_t [8] = '{28'h5555555, 28'h0800000, 28'h8000000, 28'h1100000,
                           28'h1000000, 28'h4000000, 28'h30C0000, 28'hAAAAAAA};
  logic [4:0]  f_r [4] = '{5'd1, 5'd2, 5'd9, 5'd10};

  task automatic test_reset();
    rst_n = 1'b0;
    bus.round = 5'd1;
    bus.in28 = '0;
    bus.in_valid = 1'b0;
    #3;
    n_cmp++;
    if (bus.out28_q !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_out28_q got %h want %h", bus.out28_q, 28'h0);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotate();
    for (int k = 0; k < 8; k++) begin
      bus.round = r_t[k];
      bus.in28 = i_t[k];
      #1;
      n_cmp++;
      if (bus.out28 !== o_t[k] || bus.round_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rotate r=%0d in=%h got %h err=%b want %h err=0", r_t[k], i_t[k], bus.out28, bus.round_err, o_t[k]);
      end
    end
  endtask

  task automatic test_flat();
    logic [27:0] v;
    for (int k = 0; k < 8; k++) begin
      v = (k < 4) ? 28'h0 : 28'hFFFFFFF;
      bus.round = f_r[k % 4];
      bus.in28 = v;
      #1;
      n_cmp++;
      if (bus.out28 !== v || bus.round_err !== 1'b0) begin
        n_bad++;
        $display("FAIL flat r=%0d got %h err=%b want %h err=0", f_r[k % 4], bus.out28, bus.round_err, v);
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] rr [3] = '{5'd0, 5'd17, 5'd31};
    for (int k = 0; k < 3; k++) begin
      bus.round = rr[k];
      bus.in28 = 28'h1234567;
      #1;
      n_cmp++;
      if (bus.out28 !== 28'h1234567 || bus.round_err !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal r=%0d got %h err=%b want 1234567 err=1", rr[k], bus.out28, bus.round_err);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    bus.round = 5'd3;
    bus.in28 = 28'h4000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out28_q !== 28'h1000000 || bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reg_capture got %h v=%b want 1000000 v=1", bus.out28_q, bus.out_valid);
    end
    @(negedge clk);
    bus.round = 5'd1;
    bus.in28 = 28'hAAAAAAA;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out28_q !== 28'h1000000 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reg_hold got %h v=%b want 1000000 v=0", bus.out28_q, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.round = r_t[k];
      bus.in28 = i_t[k];
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out28_q !== o_t[k] || bus.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b k=%0d got %h v=%b want %h v=1", k, bus.out28_q, bus.out_valid, o_t[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out28_q !== 28'h0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got %h v=%b want 0000000 v=0", bus.out28_q, bus.out_valid);
    end
    bus.round = 5'd2;
    bus.in28 = 28'h1000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out28_q !== 28'h0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held got %h v=%b want 0000000 v=0", bus.out28_q, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out28_q !== 28'h0800000 || bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_capture got %h v=%b want 0800000 v=1", bus.out28_q, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_flat();
    test_illegal();
    test_registered();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
